coin_change_dispenser: RTL and testbench

- Return-side counterpart of the coffee vending controller.
- The controller computes a refund in units of 100 (Coin count, over-payment, or the return button) and hands it to this block with a one-cycle request.
- The block drives the coin hoppers one coin at a time: 500 coins greedily first, 100 coins for the rest.
- It reports progress, coins ejected, completion and fault status back to the controller.

---
 rtl/coin_change_dispenser_pkg.sv | 26 ++
 rtl/dispense_timer.sv | 35 +++
 rtl/coin_change_dispenser.sv | 180 ++++++++++++++++++
 tb/tb_coin_change_dispenser.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_change_dispenser_pkg.sv
// rtl/coin_change_dispenser_pkg.sv - shared constants for the coin change dispenser
package coin_change_dispenser_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEL   = 3'd1;
    localparam logic [2:0] ST_EJECT = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;
    localparam logic [2:0] ST_FAULT = 3'd5;

    localparam int UNIT_100 = 1;
    localparam int UNIT_500 = 5;

    // Coffee price in 100-units, owned by the vending controller side.
    localparam int COFFEE_PRICE = 3;

    typedef enum logic {
        COIN_100 = 1'b0,
        COIN_500 = 1'b1
    } coin_e;

    function automatic int coin_units(coin_e coin);
        return (coin == COIN_500) ? UNIT_500 : UNIT_100;
    endfunction

endpackage

// File: rtl/dispense_timer.sv
// rtl/dispense_timer.sv - loadable down-counter with zero flag, shared by eject and gap phases
module dispense_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/coin_change_dispenser.sv
// rtl/coin_change_dispenser.sv - pays a refund through the 500/100 coin hoppers, one coin at a time
module coin_change_dispenser
    import coin_change_dispenser_pkg::*;
#(
    parameter int AMT_W     = 4,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ,
    input  logic [AMT_W-1:0] AMT,
    input  logic             E100,
    input  logic             E500,
    output logic             EJ100,
    output logic             EJ500,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [AMT_W-1:0] REM,
    output logic [AMT_W-1:0] CNT
);

    // The timer runs to zero, so it is loaded with one less than the phase length.
    localparam logic [3:0]       PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0]       GAP_LD   = 4'(GAP_CYC - 1);
    localparam bit               HAS_GAP  = (GAP_CYC > 0);
    localparam logic [AMT_W-1:0] REM_500  = AMT_W'(UNIT_500);

    logic [2:0]       state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    coin_e            coin_q, coin_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ej100_q, ej100_d;
    logic             ej500_q, ej500_d;

    logic             tmr_load;
    logic [3:0]       tmr_val;
    logic             tmr_dec;
    logic             tmr_zero;

    dispense_timer #(
        .W (4)
    ) u_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        coin_d   = coin_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        ej100_d  = 1'b0;
        ej500_d  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                // A zero refund also passes through SEL, which routes it straight
                // to FIN, keeping DONE latency uniform with the coin path.
                if (REQ) begin
                    rem_d   = AMT;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SEL;
                end
            end

            ST_SEL: begin
                if (rem_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end else if ((rem_q >= REM_500) && !E500) begin
                    coin_d   = COIN_500;
                    ej500_d  = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                    state_d  = ST_EJECT;
                end else if (!E100) begin
                    coin_d   = COIN_100;
                    ej100_d  = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                    state_d  = ST_EJECT;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_FAULT;
                end
            end

            ST_EJECT: begin
                if (tmr_zero) begin
                    rem_d = rem_q - AMT_W'(coin_units(coin_q));
                    cnt_d = cnt_q + 1'b1;
                    if (HAS_GAP) begin
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LD;
                        state_d  = ST_GAP;
                    end else begin
                        state_d = ST_SEL;
                    end
                end else begin
                    ej100_d = (coin_q == COIN_100);
                    ej500_d = (coin_q == COIN_500);
                    tmr_dec = 1'b1;
                end
            end

            ST_GAP: begin
                if (tmr_zero) begin
                    state_d = ST_SEL;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ST_FIN: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            ST_FAULT: begin
                err_d  = 1'b1;
                busy_d = 1'b1;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
            coin_q  <= COIN_100;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ej100_q <= 1'b0;
            ej500_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            coin_q  <= coin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ej100_q <= ej100_d;
            ej500_q <= ej500_d;
        end
    end

    assign EJ100 = ej100_q;
    assign EJ500 = ej500_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign ERR   = err_q;
    assign REM   = rem_q;
    assign CNT   = cnt_q;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// tb/tb_coin_change_dispenser.sv - scoreboard bench for coin_change_dispenser
module tb_coin_change_dispenser;

    localparam int AMT_W       = 4;
    localparam int PULSE       = 2;
    localparam int GAP         = 1;
    localparam int COIN_PERIOD = 1 + PULSE + GAP;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req = 1'b0;
    logic [AMT_W-1:0] amt = '0;
    logic             e100 = 1'b0;
    logic             e500 = 1'b0;
    logic             ej100, ej500, busy, done, err;
    logic [AMT_W-1:0] rem, cnt;

    coin_change_dispenser #(
        .AMT_W     (AMT_W),
        .PULSE_CYC (PULSE),
        .GAP_CYC   (GAP)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .REQ   (req),
        .AMT   (amt),
        .E100  (e100),
        .E500  (e500),
        .EJ100 (ej100),
        .EJ500 (ej500),
        .BUSY  (busy),
        .DONE  (done),
        .ERR   (err),
        .REM   (rem),
        .CNT   (cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int amt;
        int n500;
        int n100;
        int rem;
        bit fault;
        int req_cyc;
    } exp_t;

    exp_t exp_q[$];

    // Greedy payout against hopper availability; lim100 < 0 means unlimited 100 coins.
    function automatic exp_t model(int a, bit no500, int lim100);
        exp_t e;
        int   left100;
        e.amt   = a;
        e.n500  = 0;
        e.n100  = 0;
        e.rem   = a;
        e.fault = 1'b0;
        left100 = lim100;
        while (e.rem > 0) begin
            if (e.rem >= 5 && !no500) begin
                e.n500++;
                e.rem -= 5;
            end else if (left100 != 0) begin
                e.n100++;
                e.rem -= 1;
                if (left100 > 0) left100--;
            end else begin
                e.fault = 1'b1;
                break;
            end
        end
        e.req_cyc = 0;
        return e;
    endfunction

    // ---------------- monitor ----------------
    bit p100 = 0, p500 = 0, pdone = 0, perr = 0, fault_mode = 0;
    int w100 = 0, w500 = 0, n100 = 0, n500 = 0, last_rise = 0;

    task automatic on_rise(bit is500);
        if (fault_mode) begin
            check("strobe_after_fault", 1, 0);
        end else if (exp_q.size() == 0) begin
            check("unexpected_strobe", 1, 0);
        end else begin
            if (n100 + n500 == 0) check("first_strobe_latency", cyc - exp_q[0].req_cyc, 1);
            else                  check("coin_period", cyc - last_rise, COIN_PERIOD);
            last_rise = cyc;
            if (is500) n500++;
            else       n100++;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                p100 = 0; p500 = 0; pdone = 0; perr = 0; fault_mode = 0;
                w100 = 0; w500 = 0; n100 = 0; n500 = 0;
                continue;
            end
            if (ej100 || ej500) check("strobes_exclusive", int'(ej100 & ej500), 0);
            if (ej100 && !p100) on_rise(1'b0);
            if (ej500 && !p500) on_rise(1'b1);
            if (ej100) w100++;
            if (ej500) w500++;
            if (!ej100 && p100) begin check("ej100_width", w100, PULSE); w100 = 0; end
            if (!ej500 && p500) begin check("ej500_width", w500, PULSE); w500 = 0; end

            if (done) begin
                if (pdone) check("done_single_cycle", 1, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.fault) check("done_when_fault_expected", 1, 0);
                    check("done_latency", cyc - e.req_cyc, 1 + (e.n500 + e.n100) * COIN_PERIOD);
                    check("done_n500", n500, e.n500);
                    check("done_n100", n100, e.n100);
                    check("done_cnt", int'(cnt), e.n500 + e.n100);
                    check("done_rem", int'(rem), 0);
                    check("done_err", int'(err), 0);
                    check("done_busy", int'(busy), 1);
                end
                n100 = 0; n500 = 0;
            end

            if (err && !perr) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_err", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("err_expected", 1, int'(e.fault));
                    check("fault_rem", int'(rem), e.rem);
                    check("fault_cnt", int'(cnt), e.n500 + e.n100);
                    check("fault_n100", n100, e.n100);
                    check("fault_n500", n500, e.n500);
                    check("fault_busy", int'(busy), 1);
                end
                fault_mode = 1;
            end

            p100 = ej100; p500 = ej500; pdone = done; perr = err;
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(int a, bit no500, int lim100, output exp_t e);
        @(negedge clk);
        req = 1'b1;
        amt = AMT_W'(a);
        @(negedge clk);
        req = 1'b0;
        e = model(a, no500, lim100);
        e.req_cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic stray_req(int a);
        @(negedge clk);
        if (busy) begin
            req = 1'b1;
            amt = AMT_W'(a);
            @(negedge clk);
            req = 1'b0;
        end
    endtask

    task automatic wait_drain(string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic finish_tx(exp_t e);
        wait_drain("tx_timeout");
        @(negedge clk);
        @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_cnt_held", int'(cnt), e.n500 + e.n100);
        check("idle_rem", int'(rem), 0);
    endtask

    task automatic wait_level(ref logic sig, input logic lvl, input string name);
        int n = 0;
        while (sig !== lvl && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(sig), int'(lvl));
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_ej100"}, int'(ej100), 0);
        check({tag, "_ej500"}, int'(ej500), 0);
        check({tag, "_busy"},  int'(busy), 0);
        check({tag, "_done"},  int'(done), 0);
        check({tag, "_err"},   int'(err), 0);
        check({tag, "_rem"},   int'(rem), 0);
        check({tag, "_cnt"},   int'(cnt), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   a;
        bit   no500;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        do_req(8, 1'b0, -1, e);
        finish_tx(e);

        do_req(12, 1'b0, -1, e);
        finish_tx(e);

        e500 = 1'b1;
        do_req(7, 1'b1, -1, e);
        finish_tx(e);
        e500 = 1'b0;

        // 100-coin hopper runs dry after the first coin.
        do_req(3, 1'b0, 1, e);
        wait_level(ej100, 1'b1, "fault_first_pulse_seen");
        wait_level(ej100, 1'b0, "fault_first_pulse_end");
        e100 = 1'b1;
        wait_drain("fault_timeout");
        repeat (10) @(negedge clk);
        check("fault_hold_err", int'(err), 1);
        check("fault_hold_busy", int'(busy), 1);
        check("fault_hold_rem", int'(rem), 2);
        check("fault_hold_cnt", int'(cnt), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e100 = 1'b0;
        check_all_zero("after_fault_rst");

        do_req(0, 1'b0, -1, e);
        finish_tx(e);

        do_req(2, 1'b0, -1, e);
        repeat (2) @(negedge clk);
        stray_req(9);
        finish_tx(e);

        // Reset while a 500 strobe is high abandons the transaction.
        do_req(6, 1'b0, -1, e);
        wait_level(ej500, 1'b1, "rst_ej500_seen");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check_all_zero("mid_eject_rst");

        do_req(1, 1'b0, -1, e);
        finish_tx(e);

        for (int i = 0; i < 25; i++) begin
            a     = int'($urandom_range(0, 15));
            no500 = ($urandom_range(0, 3) == 0);
            e500  = no500;
            do_req(a, no500, -1, e);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                stray_req(int'($urandom_range(0, 15)));
            end
            finish_tx(e);
        end
        e500 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
